// File: rtl/cook_timer_ctrl.sv
// cook_timer_ctrl: keypad entry, load strobe, 1 s tick and magnetron control for a 3-digit countdown
module cook_timer_ctrl #(
    parameter int TICK_DIV = 100
) (
    input  logic       clock,
    input  logic       clrn,
    input  logic       key_valid,
    input  logic [3:0] key_digit,
    input  logic       start,
    input  logic       stop,
    input  logic       clear,
    input  logic       door_closed,
    input  logic       all_zero,
    output logic       loadn,
    output logic       cnt_en,
    output logic [3:0] data_min,
    output logic [3:0] data_sec_tens,
    output logic [3:0] data_sec_ones,
    output logic       mag_on,
    output logic       done,
    output logic [2:0] state
);
    localparam int PW = $clog2(TICK_DIV);
    localparam logic [PW-1:0] PMAX = PW'(TICK_DIV - 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ENTRY = 3'd1,
        LOAD  = 3'd2,
        RUN   = 3'd3,
        PAUSE = 3'd4,
        DONE  = 3'd5
    } state_t;

    state_t        cur, nxt;
    logic [3:0]    ent_min, ent_tens, ent_ones;
    logic [PW-1:0] presc;
    logic          key_ok, entry_nz, shift;

    assign key_ok        = key_valid && (key_digit <= 4'd9);
    assign entry_nz      = |{ent_min, ent_tens, ent_ones};
    assign data_min      = ent_min;
    assign data_sec_tens = (ent_tens > 4'd5) ? 4'd5 : ent_tens;
    assign data_sec_ones = ent_ones;
    assign state         = cur;

    // state register; reset drops every state-decoded output at once
    always_ff @(posedge clock or negedge clrn) begin
        if (!clrn) cur <= IDLE;
        else       cur <= nxt;
    end

    // next state, key acceptance and control outputs; clear overrides everything
    always_comb begin
        nxt    = cur;
        shift  = 1'b0;
        loadn  = 1'b1;
        mag_on = 1'b0;
        done   = 1'b0;
        cnt_en = 1'b0;
        case (cur)
            IDLE: begin
                if (!stop && key_ok) begin
                    nxt   = ENTRY;
                    shift = 1'b1;
                end
            end
            ENTRY: begin
                if (stop) nxt = ENTRY;
                else if (start && door_closed && entry_nz) nxt = LOAD;
                else if (key_ok) shift = 1'b1;
            end
            LOAD: begin
                loadn = 1'b0;
                nxt   = RUN;
            end
            RUN: begin
                mag_on = 1'b1;
                cnt_en = (presc == PMAX) && !all_zero;
                if (stop || !door_closed) nxt = PAUSE;
                else if (all_zero) nxt = DONE;
            end
            PAUSE: begin
                if (stop) nxt = IDLE;
                else if (start && door_closed) nxt = RUN;
            end
            DONE: begin
                done = 1'b1;
                if (stop || !door_closed || key_valid) nxt = IDLE;
            end
            default: nxt = IDLE;
        endcase
        if (clear) begin
            nxt   = IDLE;
            shift = 1'b0;
        end
    end

    // entry digits shift left on each accepted key and empty whenever IDLE is entered
    always_ff @(posedge clock or negedge clrn) begin
        if (!clrn) begin
            ent_min  <= 4'd0;
            ent_tens <= 4'd0;
            ent_ones <= 4'd0;
        end else if (nxt == IDLE) begin
            ent_min  <= 4'd0;
            ent_tens <= 4'd0;
            ent_ones <= 4'd0;
        end else if (shift) begin
            ent_min  <= ent_tens;
            ent_tens <= ent_ones;
            ent_ones <= key_digit;
        end
    end

    // tick prescaler: restarts on load, advances only while RUN continues, held across pause
    always_ff @(posedge clock or negedge clrn) begin
        if (!clrn) presc <= '0;
        else if (cur == LOAD) presc <= '0;
        else if (cur == RUN && nxt == RUN) presc <= (presc == PMAX) ? '0 : presc + 1'b1;
    end
endmodule
